tt_sweep: RTL
=============

Name: tt_sweep

Overview:
- Sequential stimulus-and-capture stage that sits directly upstream of a small combinational function block (e.g. func_mux4).
- Drives the block's inputs through every combination in ascending binary order, waits a programmable settle time, and samples the block's output.
- Assembles the samples into a truth-table word, so the function can be exercised and checked in hardware rather than only by a printing bench.

Parameters:
- N_IN, 3, number of function inputs; the truth table has 2**N_IN entries.
- SETTLE, 1, extra cycles each vector is held before its output is sampled; 0 is legal.
- EXP_TT, 8'h00 (width 2**N_IN), expected truth table; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- stim  out  N_IN  stimulus to the function block; bit N_IN-1 drives A, bit 0 drives the LSB input (C for N_IN=3).
- F  in  1  output of the function block, sampled by this block.
- busy  out  1  high from the cycle after start is accepted through the last sample cycle.
- done  out  1  one-cycle pulse when the truth table is complete.
- tt  out  2**N_IN  captured table; tt[i] = F observed with stim == i.
- mismatch  out  1  tt != EXP_TT after done; optional feature only.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - stim=0, tt=0, busy=0, done=0, mismatch=0.
  - State goes to IDLE and the settle counter clears.
  - Reset asserted mid-sweep aborts the sweep, with no done pulse.
- FSM states are IDLE, WAIT, DONE.
- IDLE:
  - outputs hold their values; tt keeps the last table.
  - start=1 → stim<=0, tt<=0, mismatch<=0, wcnt<=SETTLE, busy<=1, go to WAIT.
- WAIT:
  - if wcnt != 0: wcnt<=wcnt-1 and stim holds.
  - if wcnt == 0: tt[stim]<=F (sample cycle).
    - If stim == 2**N_IN-1: go to DONE.
    - Else: stim<=stim+1, wcnt<=SETTLE, stay in WAIT.
- DONE:
  - done=1 for exactly this cycle and busy=0.
  - stim<=0, then go to IDLE.
  - start in this cycle is ignored.
- Timing:
  - Each vector is presented for exactly SETTLE+1 cycles; F is sampled on the last of them.
  - WAIT lasts 2**N_IN*(SETTLE+1) cycles.
  - done is high in cycle 2**N_IN*(SETTLE+1)+1 after the start-accept edge; for defaults, that is 17.
- start while busy or in DONE is ignored; no queuing.
- stim never wraps during a sweep. The terminal compare ends the sweep before the increment would overflow.
- wcnt width is $clog2(SETTLE+1), minimum 1.
- F is assumed synchronous to clk and is not synchronized internally.

Optional Feature:
- Macro: TT_SWEEP_CHECK_EN.
- Defined: in the DONE cycle, mismatch<=(tt_next != EXP_TT), where tt_next includes the final sample. mismatch holds until the next start or reset.
- Not defined: mismatch is tied to 0, no comparator is built, and EXP_TT is unused.

Decomposition:
- Package tt_sweep_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, DONE} sweep_state_t;
  - a localparam function for table width (2**N).
- One natural sub-module, tt_settle_timer:
  - loadable down-counter with load, load value SETTLE, and zero flag.
  - Instantiated once for wcnt.
- Everything else stays in tt_sweep.

Test Plan:
- F driven by a model of func_mux4 with F = (stim==3'b101), default params; pulse start → stim steps 0..7, each held 2 cycles; done in cycle 17; tt=8'h20; busy high for cycles 1-16.
- F = ^stim (3-input parity), SETTLE=0 → each vector held 1 cycle; done in cycle 9; tt=8'h96.
- F tied 1, then a second start after done with F tied 0 → first tt=8'hFF; tt clears to 8'h00 at the second accept and ends 8'h00.
- rst asserted at cycle 6 of a sweep → next edge: stim=0, tt=0, busy=0; no done pulse; a later start runs a full clean sweep.
- start pulsed again at cycles 3 and 10 of a sweep, and in the DONE cycle → all ignored; exactly one done pulse; timing unchanged.
- TT_SWEEP_CHECK_EN defined, EXP_TT=8'h96, F = parity → mismatch=0; F = parity with entry 7 forced to 0 (tt=8'h16) → mismatch=1 after done.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types and width helpers for the tt_sweep truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    function automatic int tt_width(input int n);
        return 32'sd1 << n;
    endfunction

    // A settle count of zero still needs a one-bit counter.
    function automatic int cnt_width(input int settle);
        return (settle < 32'sd1) ? 32'sd1 : $clog2(settle + 32'sd1);
    endfunction

endpackage

// File: rtl/tt_sweep_if.sv
// Stimulus/capture bundle between tt_sweep (slave side) and its controller/function block.
interface tt_sweep_if import tt_sweep_pkg::*; #(
    parameter int N_IN = 3
);
    localparam int TT_W = tt_width(N_IN);

    logic            start;
    logic [N_IN-1:0] stim;
    logic            F;
    logic            busy;
    logic            done;
    logic [TT_W-1:0] tt;
    logic            mismatch;

    modport master (output start, F, input stim, busy, done, tt, mismatch);
    modport slave  (input start, F, output stim, busy, done, tt, mismatch);
endinterface

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that holds each stimulus vector for SETTLE extra cycles.
module tt_settle_timer #(
    parameter int SETTLE = 1,
    parameter int W      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam logic [W-1:0] LOAD_VAL = W'(SETTLE);

    logic [W-1:0] cnt_r;

    // Count register: load wins over decrement, and decrement stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});
endmodule

// File: rtl/tt_sweep.sv
// Sweeps a combinational block's inputs in ascending order and captures its truth table.
// Optional expected-table comparator enabled by defining TT_SWEEP_CHECK_EN.
module tt_sweep import tt_sweep_pkg::*; #(
    parameter int                          N_IN   = 3,
    parameter int                          SETTLE = 1,
    parameter logic [tt_width(N_IN)-1:0]   EXP_TT = {tt_width(N_IN){1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    tt_sweep_if.slave    bus
);
    localparam int              TT_W      = tt_width(N_IN);
    localparam int              CW        = cnt_width(SETTLE);
    localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};

    sweep_state_t    state_r;
    logic [N_IN-1:0] stim_r;
    logic [TT_W-1:0] tt_r;
    logic [TT_W-1:0] tt_next_s;
    logic            busy_r;
    logic            done_r;
    logic            zero_s;
    logic            load_s;
    logic            dec_s;
    logic            last_s;

    // Next table value and settle-timer controls derived from the current state.
    always_comb begin
        tt_next_s         = tt_r;
        tt_next_s[stim_r] = bus.F;
        last_s            = (stim_r == STIM_LAST);
        load_s            = 1'b0;
        dec_s             = 1'b0;
        case (state_r)
            IDLE: load_s = bus.start;
            WAIT: begin
                if (zero_s) begin
                    load_s = !last_s;
                end else begin
                    dec_s = 1'b1;
                end
            end
            default: begin
                load_s = 1'b0;
                dec_s  = 1'b0;
            end
        endcase
    end

    tt_settle_timer #(
        .SETTLE (SETTLE),
        .W      (CW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .dec  (dec_s),
        .zero (zero_s)
    );

    // Sweep controller; the terminal compare stops stim before it could wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            stim_r  <= {N_IN{1'b0}};
            tt_r    <= {TT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        stim_r  <= {N_IN{1'b0}};
                        tt_r    <= {TT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (zero_s) begin
                        tt_r <= tt_next_s;
                        if (last_s) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            stim_r <= stim_r + N_IN'(1);
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    stim_r  <= {N_IN{1'b0}};
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef TT_SWEEP_CHECK_EN
    logic mismatch_r;

    // Compare the completed table (including the final sample) against EXP_TT.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_r <= 1'b0;
        end else if ((state_r == IDLE) && bus.start) begin
            mismatch_r <= 1'b0;
        end else if ((state_r == WAIT) && zero_s && last_s) begin
            mismatch_r <= (tt_next_s != EXP_TT);
        end else begin
            mismatch_r <= mismatch_r;
        end
    end

    assign bus.mismatch = mismatch_r;
`else
    // Constant zero; the EXP_TT term folds away and builds no comparator.
    assign bus.mismatch = 1'b0 & (^EXP_TT);
`endif

    assign bus.stim = stim_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.tt   = tt_r;
endmodule
